// File: rtl/fwd_hazard_ctrl_if.sv
// fwd_hazard_ctrl_if: ID-stage instruction fields in, forwarding selects and pipeline controls out
interface fwd_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W = 32
);
  logic id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic [REG_ADDR_W-1:0] id_rd;
  logic id_reg_write;
  logic id_mem_read;
  logic id_is_mult;
  logic [1:0] select_fw_a;
  logic [1:0] select_fw_b;
  logic stall;
  logic ex_hold;
  logic ex_bubble;
  logic mem_bubble;
  logic [CNT_W-1:0] stall_cycles;
  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_reg_write, id_mem_read, id_is_mult,
    input select_fw_a, select_fw_b, stall, ex_hold, ex_bubble, mem_bubble, stall_cycles
  );
  modport slave (
    input id_valid, id_rs1, id_rs2, id_rd, id_reg_write, id_mem_read, id_is_mult,
    output select_fw_a, select_fw_b, stall, ex_hold, ex_bubble, mem_bubble, stall_cycles
  );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: EX forwarding selects and load-use/multiply stall control; FWD_HAZARD_STATS_EN adds a stall-cycle counter
module fwd_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int MULT_LAT = 4,
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic rst,
  fwd_hazard_ctrl_if.slave bus
);
  typedef struct packed {
    logic valid;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic reg_write;
    logic mem_read;
    logic is_mult;
  } slot_t;
  slot_t id_s, ex_s, mem_s, wb_s;
  logic [3:0] mult_cnt;
  logic mult_stall, load_use;
  function automatic logic hit(slot_t s, logic [REG_ADDR_W-1:0] r);
    return s.valid && s.reg_write && s.rd != '0 && s.rd == r;
  endfunction
  function automatic logic [1:0] sel(slot_t m, slot_t w, logic [REG_ADDR_W-1:0] r);
    return hit(m, r) ? 2'b10 : hit(w, r) ? 2'b01 : 2'b00;
  endfunction
  // hazard detection and forwarding selects from the shadow slots; reset forces every output low
  always_comb begin
    id_s = bus.id_valid ? {1'b1, bus.id_rs1, bus.id_rs2, bus.id_rd, bus.id_reg_write, bus.id_mem_read, bus.id_is_mult} : '0;
    mult_stall = ex_s.valid && ex_s.is_mult && mult_cnt != '0;
    load_use = !mult_stall && ex_s.valid && ex_s.mem_read && ex_s.rd != '0 && id_s.valid
               && (id_s.rs1 == ex_s.rd || id_s.rs2 == ex_s.rd);
    bus.select_fw_a = (rst || !ex_s.valid) ? 2'b00 : sel(mem_s, wb_s, ex_s.rs1);
    bus.select_fw_b = (rst || !ex_s.valid) ? 2'b00 : sel(mem_s, wb_s, ex_s.rs2);
    bus.stall = !rst && (mult_stall || load_use);
    bus.ex_hold = !rst && mult_stall;
    bus.mem_bubble = !rst && mult_stall;
    bus.ex_bubble = !rst && load_use;
  end
  // shadow pipeline advance: multiply holds EX, load-use inserts a bubble into EX
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_s <= '0;
      mem_s <= '0;
      wb_s <= '0;
      mult_cnt <= '0;
    end else begin
      wb_s <= mem_s;
      mem_s <= mult_stall ? '0 : ex_s;
      ex_s <= mult_stall ? ex_s : load_use ? '0 : id_s;
      mult_cnt <= (!mult_stall && !load_use && id_s.valid && id_s.is_mult) ? 4'(MULT_LAT - 1)
                  : mult_cnt != '0 ? mult_cnt - 4'd1 : 4'd0;
    end
  end
`ifdef FWD_HAZARD_STATS_EN
  logic [CNT_W-1:0] cnt;
  // saturating count of stalled cycles
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (bus.stall && !(&cnt)) cnt <= cnt + 1'b1;
  end
  assign bus.stall_cycles = cnt;
`else
  assign bus.stall_cycles = '0;
`endif
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb_fwd_hazard_ctrl: table-driven per-cycle checks of forwarding selects and stall controls
module tb_fwd_hazard_ctrl;
  logic clk = 0;
  logic rst;
  int checks = 0;
  int failures = 0;
  fwd_hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(32)) bus ();
  fwd_hazard_ctrl #(.REG_ADDR_W(5), .MULT_LAT(4), .CNT_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {
    logic rst, v;
    logic [4:0] rs1, rs2, rd;
    logic rw, mr, mu;
    logic [1:0] fa, fb;
    logic st, hd, eb, mb;
  } vec_t;
  vec_t q[$];

  function automatic vec_t r(logic rs, logic v, int a, int b, int d, logic rw, logic mr, logic mu,
                             logic [1:0] fa, logic [1:0] fb, logic st, logic hd, logic eb, logic mb);
    vec_t x;
    x.rst = rs; x.v = v; x.rs1 = 5'(a); x.rs2 = 5'(b); x.rd = 5'(d);
    x.rw = rw; x.mr = mr; x.mu = mu; x.fa = fa; x.fb = fb;
    x.st = st; x.hd = hd; x.eb = eb; x.mb = mb;
    return x;
  endfunction

  task automatic chk(string n, int step, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%0h expected=%0h", n, step, act, exp);
    end
  endtask

  task automatic apply(vec_t x, int step);
    @(negedge clk);
    rst = x.rst;
    bus.id_valid = x.v; bus.id_rs1 = x.rs1; bus.id_rs2 = x.rs2; bus.id_rd = x.rd;
    bus.id_reg_write = x.rw; bus.id_mem_read = x.mr; bus.id_is_mult = x.mu;
    #1;
    chk("select_fw_a", step, 32'(bus.select_fw_a), 32'(x.fa));
    chk("select_fw_b", step, 32'(bus.select_fw_b), 32'(x.fb));
    chk("stall", step, 32'(bus.stall), 32'(x.st));
    chk("ex_hold", step, 32'(bus.ex_hold), 32'(x.hd));
    chk("ex_bubble", step, 32'(bus.ex_bubble), 32'(x.eb));
    chk("mem_bubble", step, 32'(bus.mem_bubble), 32'(x.mb));
    checks++;
    if ((bus.select_fw_a == 2'b10 || bus.select_fw_b == 2'b10) && dut.mem_s.valid && dut.mem_s.mem_read) begin
      failures++;
      $display("FAIL load_fwd_from_mem step=%0d", step);
    end
  endtask

  initial begin
    vec_t nop, mul;
    nop = r(0,0,0,0,0,0,0,0, 2'b00,2'b00,0,0,0,0);
    rst = 1;
    // reset
    q.push_back(r(1,0,0,0,0,0,0,0, 2'b00,2'b00,0,0,0,0));
    q.push_back(r(1,0,0,0,0,0,0,0, 2'b00,2'b00,0,0,0,0));
    // add x5,x1,x2 ; sub x6,x5,x3 -> A from EX/MEM
    q.push_back(r(0,1,1,2,5,1,0,0, 2'b00,2'b00,0,0,0,0));
    q.push_back(r(0,1,5,3,6,1,0,0, 2'b00,2'b00,0,0,0,0));
    q.push_back(r(0,0,0,0,0,0,0,0, 2'b10,2'b00,0,0,0,0));
    q.push_back(nop);
    // add x5 ; nop ; or x7,x4,x5 -> B from writeback
    q.push_back(r(0,1,1,2,5,1,0,0, 2'b00,2'b00,0,0,0,0));
    q.push_back(nop);
    q.push_back(r(0,1,4,5,7,1,0,0, 2'b00,2'b00,0,0,0,0));
    q.push_back(r(0,0,0,0,0,0,0,0, 2'b00,2'b01,0,0,0,0));
    // lw x8 ; add x9,x8,x8 -> one bubble then both from writeback
    q.push_back(r(0,1,1,0,8,1,1,0, 2'b00,2'b00,0,0,0,0));
    q.push_back(r(0,1,8,8,9,1,0,0, 2'b00,2'b00,1,0,1,0));
    q.push_back(r(0,1,8,8,9,1,0,0, 2'b00,2'b00,0,0,0,0));
    q.push_back(r(0,0,0,0,0,0,0,0, 2'b01,2'b01,0,0,0,0));
    // mul x10 ; independent add x11 held three cycles
    q.push_back(r(0,1,1,2,10,1,0,1, 2'b00,2'b00,0,0,0,0));
    for (int i = 0; i < 3; i++) q.push_back(r(0,1,3,4,11,1,0,0, 2'b00,2'b00,1,1,0,1));
    q.push_back(r(0,1,3,4,11,1,0,0, 2'b00,2'b00,0,0,0,0));
    q.push_back(nop);
    // x0 never forwards or stalls
    q.push_back(r(0,1,1,2,0,1,0,0, 2'b00,2'b00,0,0,0,0));
    q.push_back(r(0,1,0,0,1,1,0,0, 2'b00,2'b00,0,0,0,0));
    q.push_back(nop);
    q.push_back(r(0,1,3,0,0,1,1,0, 2'b00,2'b00,0,0,0,0));
    q.push_back(r(0,1,0,0,2,1,0,0, 2'b00,2'b00,0,0,0,0));
    q.push_back(nop);
    // invalid ID reading a load destination does not stall
    q.push_back(r(0,1,3,0,8,1,1,0, 2'b00,2'b00,0,0,0,0));
    q.push_back(r(0,0,8,8,0,0,0,0, 2'b00,2'b00,0,0,0,0));
    // MEM result has priority over WB
    q.push_back(r(0,1,1,2,5,1,0,0, 2'b00,2'b00,0,0,0,0));
    q.push_back(r(0,1,3,4,5,1,0,0, 2'b00,2'b00,0,0,0,0));
    q.push_back(r(0,1,5,5,6,1,0,0, 2'b00,2'b00,0,0,0,0));
    q.push_back(r(0,0,0,0,0,0,0,0, 2'b10,2'b10,0,0,0,0));
    // back-to-back multiplies reload the counter
    q.push_back(r(0,1,1,2,12,1,0,1, 2'b00,2'b00,0,0,0,0));
    for (int i = 0; i < 3; i++) q.push_back(r(0,1,3,4,13,1,0,1, 2'b00,2'b00,1,1,0,1));
    q.push_back(r(0,1,3,4,13,1,0,1, 2'b00,2'b00,0,0,0,0));
    for (int i = 0; i < 3; i++) q.push_back(r(0,0,0,0,0,0,0,0, 2'b00,2'b00,1,1,0,1));
    q.push_back(nop);
    // reset during the second multiply-busy cycle
    q.push_back(r(0,1,5,6,14,1,0,1, 2'b00,2'b00,0,0,0,0));
    q.push_back(r(0,0,0,0,0,0,0,0, 2'b00,2'b00,1,1,0,1));
    q.push_back(r(1,0,0,0,0,0,0,0, 2'b00,2'b00,0,0,0,0));
    q.push_back(nop);
    foreach (q[i]) apply(q[i], i);
    chk("stall_cycles_after_rst", 0, bus.stall_cycles, 32'd0);
    // full multiply after reset: three stalled cycles counted
    mul = r(0,1,1,2,15,1,0,1, 2'b00,2'b00,0,0,0,0);
    apply(mul, 100);
    for (int i = 0; i < 3; i++) apply(r(0,0,0,0,0,0,0,0, 2'b00,2'b00,1,1,0,1), 101 + i);
    apply(nop, 104);
`ifdef FWD_HAZARD_STATS_EN
    chk("stall_cycles_after_mul", 104, bus.stall_cycles, 32'd3);
`else
    chk("stall_cycles_after_mul", 104, bus.stall_cycles, 32'd0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
